// File: rtl/mcu_dmem_ram_ctrl.sv
// mcu_dmem_ram_ctrl: zero-scrubbed data RAM slave on the core req/gnt/rvalid port.
// Define MCU_DMEM_OUTREG_EN for an extra response register stage (2-cycle latency).
module mcu_dmem_ram_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        init_done_o
);
  typedef enum logic {INIT, READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rvalid_q, rvalid_d, err_q, err_d, rd_q, rd_d;
  logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];
  logic [31:0]           ram_q;
  logic                  hit, wen;
  logic [ADDR_WIDTH-1:0] idx, waddr;
  logic [3:0]            wbe;
  logic [31:0]           wdat, rdata1;
  logic                  unused;
  assign unused     = ^data_addr_i[1:0];
  assign hit        = data_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign idx        = data_addr_i[ADDR_WIDTH+1:2];
  assign data_gnt_o = data_req_i & (state_q == READY);
  assign rdata1     = rd_q ? ram_q : '0;
  always_comb begin
    state_d     = (state_q == INIT && cnt_q == '1) ? READY : state_q;
    cnt_d       = (state_q == INIT) ? cnt_q + ADDR_WIDTH'(1) : cnt_q;
    init_done_d = state_d == READY;
    rvalid_d    = data_gnt_o;
    err_d       = data_gnt_o & ~hit;
    rd_d        = data_gnt_o & hit & ~data_we_i;
    wen         = (state_q == INIT) | (data_gnt_o & hit & data_we_i);
    waddr       = (state_q == INIT) ? cnt_q : idx;
    wbe         = (state_q == INIT) ? 4'hF : data_be_i;
    wdat        = (state_q == INIT) ? '0 : data_wdata_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
    end
  end
  // Block RAM has no reset; the scrub shares the single write port with the core.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (wen && wbe[b]) mem[waddr][8*b +: 8] <= wdat[8*b +: 8];
    if (rd_d) ram_q <= mem[idx];
  end
  assign init_done_o = init_done_q;
`ifdef MCU_DMEM_OUTREG_EN
  logic        rvalid2_q, err2_q;
  logic [31:0] rdata2_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid2_q <= 1'b0;
      err2_q    <= 1'b0;
      rdata2_q  <= '0;
    end else begin
      rvalid2_q <= rvalid_q;
      err2_q    <= err_q;
      rdata2_q  <= rdata1;
    end
  end
  assign data_rvalid_o = rvalid2_q;
  assign data_err_o    = err2_q;
  assign data_rdata_o  = rdata2_q;
`else
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata1;
`endif
endmodule

// File: tb/tb_mcu_dmem_ram_ctrl.sv
// tb_mcu_dmem_ram_ctrl: scoreboard bench for mcu_dmem_ram_ctrl with directed vectors.
module tb_mcu_dmem_ram_ctrl;
`ifdef MCU_DMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, err, init_done;
  logic [31:0] rdata;
  typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
  exp_t q[$];
  exp_t m_e;
  int   checks = 0, errors = 0, cyc = 0, w;

  mcu_dmem_ram_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_req_i(req), .data_gnt_o(gnt),
    .data_rvalid_o(rvalid), .data_we_i(we), .data_be_i(be), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_rdata_o(rdata), .data_err_o(err), .init_done_o(init_done)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rvalid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid got rvalid=1 expected no response at cycle %0d", cyc);
      end else begin
        m_e = q.pop_front();
        chk("rdata", rdata, m_e.rdata);
        chk("err", {31'b0, err}, {31'b0, m_e.err});
        chk("latency", cyc - m_e.cyc, LAT);
      end
    end else begin
      chk("idle_zero", rdata | {31'b0, err}, 32'h0);
    end
  end

  task automatic issue(input logic wr, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, output int waits);
    req = 1'b1; we = wr; be = b; addr = a; wdata = d; waits = 0;
    #1;
    while (!gnt && waits < 5000) begin
      @(posedge clk_i); #1; #1;
      waits++;
    end
    if (!gnt) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout got gnt=0 expected gnt within 5000 cycles addr %0h", a);
    end else q.push_back('{er, ee, cyc});
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    req = 1'b1; addr = 32'h0010_0000;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_gnt", {31'b0, gnt}, 0);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_init_done", {31'b0, init_done}, 0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    issue(1'b0, 4'hF, 32'h0010_0000, 0, 32'h0, 1'b0, w);
    chk("scrub_wait", w, 4096);
    chk("init_done", {31'b0, init_done}, 1);
    issue(1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 0, 1'b0, w);
    issue(1'b1, 4'h1, 32'h0010_0010, 32'h0000_0055, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0010_0010, 0, 32'hDEAD_BE55, 1'b0, w);
    issue(1'b1, 4'h0, 32'h0010_0010, 32'hFFFF_FFFF, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0010_0010, 0, 32'hDEAD_BE55, 1'b0, w);
    issue(1'b1, 4'hF, 32'h0010_0000, 32'h1234_5678, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0020_0000, 0, 0, 1'b1, w);
    issue(1'b1, 4'hF, 32'h0020_0000, 32'hFFFF_FFFF, 0, 1'b1, w);
    issue(1'b0, 4'hF, 32'h0010_4000, 0, 0, 1'b1, w);
    issue(1'b0, 4'hF, 32'h000F_FFFC, 0, 0, 1'b1, w);
    issue(1'b0, 4'hF, 32'h0010_0000, 0, 32'h1234_5678, 1'b0, w);
    issue(1'b1, 4'hF, 32'h0010_3FFC, 32'hCAFE_F00D, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0010_3FFE, 0, 32'hCAFE_F00D, 1'b0, w);
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 4'hF, 32'h0010_0020 + 4 * k, 32'hA5A5_0000 + k, 0, 1'b0, w);
      issue(1'b0, 4'hF, 32'h0010_0020 + 4 * k, 0, 32'hA5A5_0000 + k, 1'b0, w);
    end
    idle(LAT + 2);
    chk("drain1", q.size(), 0);
    issue(1'b1, 4'hF, 32'h0010_0004, 32'h1111_2222, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0010_0004, 0, 32'h1111_2222, 1'b0, w);
    req = 1'b0;
    repeat (LAT - 1) begin @(posedge clk_i); #1; end
    chk("rvalid_before_rst", {31'b0, rvalid}, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("rvalid_async_clear", {31'b0, rvalid}, 0);
    chk("rdata_async_clear", rdata, 0);
    chk("init_done_rst", {31'b0, init_done}, 0);
    q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("init_done_mid_scrub", {31'b0, init_done}, 0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    issue(1'b0, 4'hF, 32'h0010_0004, 0, 0, 1'b0, w);
    chk("rescrub_wait", w, 4096);
    issue(1'b0, 4'hF, 32'h0010_0010, 0, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0010_3FFC, 0, 0, 1'b0, w);
    issue(1'b0, 4'hF, 32'h0010_0000, 0, 0, 1'b0, w);
    idle(LAT + 2);
    chk("drain2", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
